// File: rtl/sdram_apb_master_if.sv
// Host request and APB4 bus bundle for sdram_apb_master.
// master: the requester's view; slave: host/completer side driving it.
interface sdram_apb_master_if #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 32
);
  logic                    req_i;
  logic                    we_i;
  logic [PADDR_SIZE-1:0]   addr_i;
  logic [PDATA_SIZE-1:0]   wdata_i;
  logic [PDATA_SIZE/8-1:0] be_i;
  logic [2:0]              prot_i;
  logic                    busy_o;
  logic                    ack_o;
  logic                    err_o;
  logic                    timeout_o;
  logic [PDATA_SIZE-1:0]   rdata_o;

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i, prot_i,
    output busy_o, ack_o, err_o, timeout_o, rdata_o,
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i, prot_i,
    input  busy_o, ack_o, err_o, timeout_o, rdata_o,
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/sdram_apb_master.sv
// APB4 requester: one host register access at a time, turned into SETUP/ACCESS
// transfers toward the SDRAM controller CSR port, with optional ACCESS timeout.
module sdram_apb_master #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 256
) (
  input logic                 PCLK,
  input logic                 PRESET,
  sdram_apb_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [PADDR_SIZE-1:0]   paddr_q, paddr_d;
  logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic [PDATA_SIZE/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    timeout_q, timeout_d;
  logic [PDATA_SIZE-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          pwrite_d = bus.we_i;
          paddr_d  = bus.addr_i;
          pwdata_d = bus.wdata_i;
          pstrb_d  = bus.we_i ? bus.be_i : '0;
          pprot_d  = bus.prot_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY in the last allowed cycle still completes normally
        if (bus.PREADY) begin
          ack_d   = 1'b1;
          err_d   = bus.PSLVERR;
          rdata_d = pwrite_q ? '0 : bus.PRDATA;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          ack_d     = 1'b1;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PSEL      = (state_q != IDLE);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
  assign bus.ack_o     = ack_q;
  assign bus.err_o     = err_q;
  assign bus.timeout_o = timeout_q;
  assign bus.rdata_o   = rdata_q;

endmodule

// File: doc/sdram_apb_master.md
# sdram_apb_master

APB4 requester (initiator) that turns single-word host register requests into APB SETUP/ACCESS transfers toward the SDRAM controller CSR completer. It sits between a host-side configuration engine (boot sequencer or debug port) and the APB CSR port, handling wait states, PSLVERR and an optional bus timeout. Exactly one transfer is outstanding at a time, and request fields are captured at acceptance.

## Interface
- PADDR_SIZE, 4, APB address width
- PDATA_SIZE, 32, APB data width; multiple of 8
- TIMEOUT, 256, max ACCESS cycles without PREADY before abort; 0 disables timeout
- PCLK  in  1  clock, rising edge; the only clock
- PRESET  in  1  reset, synchronous, active-high
- req_i  in  1  host request; accepted when busy_o=0
- we_i  in  1  1=write, 0=read
- addr_i  in  PADDR_SIZE  byte address
- wdata_i  in  PDATA_SIZE  write data
- be_i  in  PDATA_SIZE/8  byte enables, writes only
- prot_i  in  3  PPROT value
- busy_o  out  1  transfer in progress
- ack_o  out  1  one-cycle completion strobe
- err_o  out  1  valid with ack_o; PSLVERR or timeout
- timeout_o  out  1  valid with ack_o; abort due to timeout
- rdata_o  out  PDATA_SIZE  read data, valid with ack_o
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  PADDR_SIZE
- PSTRB  out  PDATA_SIZE/8
- PPROT  out  3
- PWDATA  out  PDATA_SIZE
- PRDATA  in  PDATA_SIZE
- PREADY, PSLVERR  in  1 each

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: busy_o=0, PSEL=0, PENABLE=0. If req_i=1, capture we/addr/wdata/be/prot into PADDR/PWRITE/PWDATA/PSTRB/PPROT registers and go to SETUP.
- SETUP: PSEL=1, PENABLE=0, busy_o=1. Always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: register rdata_o = PWRITE ? 0 : PRDATA, err_o=PSLVERR, timeout_o=0, ack_o=1; go to IDLE.
- Timeout: a counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0. When the counter reaches TIMEOUT-1 and PREADY=0 in that cycle, the transfer aborts: go to IDLE with ack_o=1, err_o=1, timeout_o=1, rdata_o=0. PREADY=1 in the same cycle wins over the timeout. Counter width is $clog2(TIMEOUT+1), and the counter saturates (never wraps). With TIMEOUT=0 the requester waits indefinitely.
- PSTRB is forced to 0 on reads (APB4 rule). PADDR, PWRITE, PWDATA, PSTRB and PPROT hold their captured values from SETUP through the final ACCESS cycle and keep those values in IDLE until the next acceptance.
- req_i is ignored while busy_o=1; the host must re-present it after ack_o.
- ack_o, err_o and timeout_o are single-cycle pulses. rdata_o holds its value until the next ack_o.

## Timing
- Reset values, all on the first PCLK edge with PRESET=1, from any state (including mid-ACCESS): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PSTRB=0, PPROT=0, PWDATA=0, busy_o=0, ack_o=0, err_o=0, timeout_o=0, rdata_o=0, timeout counter=0. A transfer aborted by reset produces no ack_o.
- Request accepted at edge N puts PSEL=1 at N+1 and PENABLE=1 at N+2.
- With PREADY=1 in the first ACCESS cycle, ack_o=1 at N+3. Each PREADY=0 cycle adds one cycle of latency.
- busy_o=1 from N+1 until the edge at which ack_o rises; busy_o=0 in the ack_o cycle.
- A req_i presented during the ack_o cycle is accepted. Back-to-back throughput is one transfer per 3 cycles with zero wait states.
- The timeout abort ack occurs TIMEOUT cycles after the first ACCESS cycle.

## Test plan
- Write, zero wait: req with we=1, addr=0x4, wdata=0xDEADBEEF, be=0xF, prot=1 -> SETUP then ACCESS with PADDR=0x4, PWDATA=0xDEADBEEF, PSTRB=0xF, PPROT=1; ack_o 3 cycles after accept, err_o=0, rdata_o=0.
- Read with 5 wait states: completer holds PREADY=0 for 5 cycles, then returns PRDATA=0x40000000 -> PSTRB=0; PENABLE high for 6 cycles; ack_o at accept+8; rdata_o=0x40000000.
- Error: PSLVERR=1 together with PREADY=1 -> ack_o=1, err_o=1, timeout_o=0; next transfer proceeds normally.
- Timeout, TIMEOUT=4: PREADY held at 0 -> PSEL drops after 4 ACCESS cycles; ack_o=1, err_o=1, timeout_o=1, rdata_o=0. Also PREADY=1 exactly in the 4th ACCESS cycle -> normal completion, timeout_o=0.
- Back-to-back: req_i held high for 3 requests -> 3 acks spaced 3 cycles apart; req_i changes while busy have no effect on PADDR or PWDATA.
- Reset mid-ACCESS: PRESET=1 asserted during a wait state -> all outputs at reset values after 1 edge, no ack_o; a new request after release works normally.
